vga_pixel_write_arbiter: RTL and testbench

Shares the single pixel-buffer write port that feeds the VGA output between NUM_REQ drawing requesters, e.g. a CPU draw master and a switch-driven pattern filler. Uses round-robin arbitration and converts (x, y, colour) requests into a linear pixel-buffer address. Drives an Avalon-MM-style write master with waitrequest. Sits between the requesters and the frame-buffer memory that the VGA scan-out reads.

---
 rtl/vga_arb_pkg.sv | 30 +++
 rtl/vga_pixel_write_arbiter_rr_arbiter.sv | 35 +++
 rtl/vga_pixel_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_vga_pixel_write_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the VGA pixel-write arbiter: FSM state
// encoding, default resolution and a colour-channel slice helper.
package vga_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    CH_B = 2'd0,
    CH_G = 2'd1,
    CH_R = 2'd2
  } color_ch_e;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  // 24-bit colour word is R[23:16], G[15:8], B[7:0].
  function automatic logic [7:0] color_field(input logic [23:0] color, input color_ch_e ch);
    case (ch)
      CH_R:    color_field = color[23:16];
      CH_G:    color_field = color[15:8];
      CH_B:    color_field = color[7:0];
      default: color_field = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/vga_pixel_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after i_ptr,
// wrapping modulo NUM_REQ. Returns a one-hot grant and the winner index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan requesters in priority order starting from the pointer.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int               w_cand;
      logic [IDX_W-1:0] w_cand_idx;
      w_cand     = int'(i_ptr) + i;
      w_cand     = (w_cand >= NUM_REQ) ? (w_cand - NUM_REQ) : w_cand;
      w_cand_idx = IDX_W'(w_cand);
      if (!o_any && i_valid[w_cand_idx]) begin
        o_any               = 1'b1;
        o_grant[w_cand_idx] = 1'b1;
        o_idx               = w_cand_idx;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/vga_pixel_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-style pixel-buffer write port between
// NUM_REQ drawing requesters. Optional bounds check: ARB_BOUNDS_CHECK_EN.
module vga_pixel_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 24,
  parameter int ADDR_W  = 17
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOR_W-1:0]   req_color,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [COLOR_W-1:0]           mem_writedata,
  output logic                         mem_write,
  input  logic                         mem_waitrequest,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         err_oob
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e          r_state;
  arb_state_e          w_next_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_grant_id;
  logic [IDX_W-1:0]    w_win;
  logic [IDX_W-1:0]    w_next_ptr;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_any;
  logic                w_accept;
  logic                w_oob;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOR_W-1:0]  r_color;
  logic [ADDR_W-1:0]   r_addr;
  logic [COLOR_W-1:0]  r_data;
  logic [ADDR_W-1:0]   w_addr;
  logic [X_W-1:0]      w_x     [NUM_REQ];
  logic [Y_W-1:0]      w_y     [NUM_REQ];
  logic [COLOR_W-1:0]  w_color [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_x[g]     = req_x[g*X_W +: X_W];
    assign w_y[g]     = req_y[g*Y_W +: Y_W];
    assign w_color[g] = req_color[g*COLOR_W +: COLOR_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  // Reset gating keeps ready quiet while the FSM is held in reset.
  assign w_accept   = (r_state == IDLE) && w_any && !reset_reset;
  assign w_next_ptr = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : (w_win + IDX_W'(1));
  assign w_addr     = ADDR_W'(int'(r_y) * H_RES + int'(r_x));

`ifdef ARB_BOUNDS_CHECK_EN
  assign w_oob = (int'(r_x) >= H_RES) || (int'(r_y) >= V_RES);
`else
  assign w_oob = 1'b0;
`endif

  assign req_ready     = w_accept ? w_grant : '0;
  assign grant_id      = w_accept ? w_win : r_grant_id;
  assign busy          = (r_state != IDLE);
  assign mem_write     = (r_state == WRITE);
  assign mem_address   = r_addr;
  assign mem_writedata = r_data;

  // State register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; an out-of-bounds request skips WRITE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_any ? ADDR : IDLE;
      ADDR:    w_next_state = w_oob ? IDLE : WRITE;
      WRITE:   w_next_state = mem_waitrequest ? WRITE : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch, round-robin pointer and address/data pipeline.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_color    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      if (w_accept) begin
        r_x        <= w_x[w_win];
        r_y        <= w_y[w_win];
        r_color    <= w_color[w_win];
        r_grant_id <= w_win;
        r_ptr      <= w_next_ptr;
      end
      if (r_state == ADDR) begin
        r_addr <= w_addr;
        r_data <= r_color;
      end
    end
  end

`ifdef ARB_BOUNDS_CHECK_EN
  logic r_err_oob;

  // Sticky until reset.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_err_oob <= 1'b0;
    end else if ((r_state == ADDR) && w_oob) begin
      r_err_oob <= 1'b1;
    end
  end

  assign err_oob = r_err_oob;
`else
  assign err_oob = 1'b0;
`endif

endmodule

// File: tb/tb_vga_pixel_write_arbiter.sv
// Self-checking bench: cycle model of the arbiter rules checked every cycle,
// plus directed literal checks from the test plan and a NUM_REQ=4 instance.
`timescale 1ns/1ps
module tb_vga_pixel_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [8:0]  bx [2];
  logic [7:0]  by [2];
  logic [23:0] bc [2];
  logic [17:0] req_x;
  logic [15:0] req_y;
  logic [47:0] req_color;
  logic [16:0] mem_address;
  logic [23:0] mem_writedata;
  logic        mem_write;
  logic        mem_waitrequest = 1'b0;
  logic        busy;
  logic [0:0]  grant_id;
  logic        err_oob;

  assign req_x     = {bx[1], bx[0]};
  assign req_y     = {by[1], by[0]};
  assign req_color = {bc[1], bc[0]};

  vga_pixel_write_arbiter u_dut (
    .clk_clk(clk), .reset_reset(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_write(mem_write), .mem_waitrequest(mem_waitrequest),
    .busy(busy), .grant_id(grant_id), .err_oob(err_oob)
  );

  // Four-requester instance for the pointer-wrap case.
  logic [3:0]  v4 = 4'b0000;
  logic [3:0]  r4;
  logic [35:0] x4 = '0;
  logic [31:0] y4 = '0;
  logic [95:0] c4 = '0;
  logic [16:0] a4;
  logic [23:0] d4;
  logic        w4, b4, e4;
  logic        wr4 = 1'b0;
  logic [1:0]  gid4;

  vga_pixel_write_arbiter #(.NUM_REQ(4)) u_dut4 (
    .clk_clk(clk), .reset_reset(rst),
    .req_valid(v4), .req_ready(r4),
    .req_x(x4), .req_y(y4), .req_color(c4),
    .mem_address(a4), .mem_writedata(d4),
    .mem_write(w4), .mem_waitrequest(wr4),
    .busy(b4), .grant_id(gid4), .err_oob(e4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: stage 0 = waiting for a request, 1 = computing address,
  // 2 = write in flight. Checked against the DUT on every falling edge.
  int          m_ptr, m_stage, m_gid, m_addr, m_out_addr, win, c;
  logic [23:0] m_data, m_out_data;
  logic        m_err, m_oob;
  logic [1:0]  er;

  initial begin
    m_ptr = 0; m_stage = 0; m_gid = 0; m_out_addr = 0; m_out_data = '0;
    m_err = 1'b0; m_addr = 0; m_data = '0; m_oob = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ptr = 0; m_stage = 0; m_gid = 0; m_out_addr = 0; m_out_data = '0; m_err = 1'b0;
        chk("rst_ready", req_ready, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_address", mem_address, 0);
        chk("rst_writedata", mem_writedata, 0);
        chk("rst_err_oob", err_oob, 0);
      end else begin
        win = -1;
        if (m_stage == 0) begin
          for (int k = 0; k < 2; k++) begin
            c = (m_ptr + k) % 2;
            if (win < 0 && req_valid[c[0]]) win = c;
          end
        end
        er = (win >= 0) ? (2'b01 << win) : 2'b00;
        chk("m_ready", req_ready, er);
        chk("m_busy", busy, m_stage != 0);
        chk("m_write", mem_write, m_stage == 2);
        chk("m_grant_id", grant_id, (win >= 0) ? win : m_gid);
        chk("m_err_oob", err_oob, m_err);
        if (m_stage == 2) begin
          chk("m_address", mem_address, m_out_addr);
          chk("m_writedata", mem_writedata, m_out_data);
        end
        case (m_stage)
          0: if (win >= 0) begin
               m_gid  = win;
               m_ptr  = (win + 1) % 2;
               m_addr = (int'(by[win[0]]) * 320 + int'(bx[win[0]])) % 131072;
               m_data = bc[win[0]];
               m_oob  = (bx[win[0]] >= 9'd320) || (by[win[0]] >= 8'd240);
               m_stage = 1;
             end
          1: begin
`ifdef ARB_BOUNDS_CHECK_EN
               if (m_oob) begin
                 m_err = 1'b1;
                 m_stage = 0;
               end else
`endif
               begin
                 m_stage = 2;
                 m_out_addr = m_addr;
                 m_out_data = m_data;
               end
             end
          default: if (!mem_waitrequest) m_stage = 0;
        endcase
      end
    end
  end

  task automatic wait_rdy(output logic [1:0] r);
    r = 2'b00;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        r = req_ready;
        break;
      end
    end
    chk("ready_seen", r != 2'b00, 1);
  endtask

  task automatic wait_rdy4(output logic [3:0] r);
    r = 4'b0000;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (r4 != 4'b0000) begin
        r = r4;
        break;
      end
    end
    chk("ready4_seen", r != 4'b0000, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  logic [1:0] r;
  logic [3:0] rr4;
  int         cnt [2];
  int         k;

  initial begin
    for (int i = 0; i < 2; i++) begin
      bx[i[0]] = '0; by[i[0]] = '0; bc[i[0]] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single request: latency and address 2*320+10.
    @(posedge clk); #1;
    bx[0] = 9'd10; by[0] = 8'd2; bc[0] = 24'hFF0000; req_valid = 2'b01;
    @(negedge clk); chk("t1_ready_T", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk); chk("t1_write_T1", mem_write, 0);
    @(negedge clk); chk("t1_write_T2", mem_write, 1);
    chk("t1_addr", mem_address, 17'd650);
    chk("t1_data", mem_writedata, 24'hFF0000);
    @(negedge clk); chk("t1_busy_T3", busy, 0);
    chk("t1_write_T3", mem_write, 0);

    // Fairness: both continuously valid, six grants each.
    do_reset();
    cnt[0] = 0; cnt[1] = 0; k = 0;
    req_valid = 2'b11;
    for (int cyc = 0; cyc < 100 && k < 12; cyc++) begin
      @(negedge clk);
      r = req_ready;
      chk("fair_onehot", $countones(r) <= 1, 1);
      if (r != 2'b00) begin
        chk("fair_order", r, (k % 2 == 0) ? 2'b01 : 2'b10);
        k++;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (r[i[0]]) begin
          cnt[i]++;
          bx[i[0]] = 9'($urandom_range(0, 319));
          by[i[0]] = 8'($urandom_range(0, 239));
          bc[i[0]] = 24'($urandom);
          if (cnt[i] >= 6) req_valid[i[0]] = 1'b0;
        end
      end
    end
    chk("fair_count", k, 12);
    repeat (4) @(posedge clk);

    // Wait states: 4 stalled cycles in WRITE.
    #1 mem_waitrequest = 1'b1;
    bx[0] = 9'd100; by[0] = 8'd50; bc[0] = 24'h00AB12; req_valid = 2'b01;
    wait_rdy(r);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("ws_write_hold", mem_write, 1);
      chk("ws_addr_hold", mem_address, 17'd16100);
      chk("ws_data_hold", mem_writedata, 24'h00AB12);
    end
    @(posedge clk); #1 mem_waitrequest = 1'b0;
    @(negedge clk); chk("ws_write_accept", mem_write, 1);
    @(negedge clk); chk("ws_write_end", mem_write, 0);

    // Reset asserted mid-WRITE.
    @(posedge clk); #1 mem_waitrequest = 1'b1;
    bx[0] = 9'd7; by[0] = 8'd3; req_valid = 2'b01;
    wait_rdy(r);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk); @(negedge clk);
    chk("rm_write_before", mem_write, 1);
    #2 rst = 1'b1;
    #1 chk("rm_write_async", mem_write, 0);
    chk("rm_busy_async", busy, 0);
    mem_waitrequest = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    bx[0] = 9'd1; by[0] = 8'd1; bx[1] = 9'd5; by[1] = 8'd1; bc[1] = 24'h00FF00;
    req_valid = 2'b11;
    wait_rdy(r); chk("rm_ptr_zero", r, 2'b01);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_rdy(r); chk("rm_req1_served", r, 2'b10);
    chk("rm_gid1", grant_id, 1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rm_write", mem_write, 1);
    chk("rm_addr", mem_address, 17'd325);
    chk("rm_data", mem_writedata, 24'h00FF00);
    repeat (2) @(posedge clk);

`ifdef ARB_BOUNDS_CHECK_EN
    // Out-of-bounds request is dropped and flagged; the next one is written.
    #1 bx[0] = 9'd320; by[0] = 8'd0; req_valid = 2'b01;
    wait_rdy(r);
    @(posedge clk); #1 req_valid = 2'b00;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); chk("oob_no_write", mem_write, 0);
    end
    chk("oob_err", err_oob, 1);
    @(posedge clk); #1 bx[1] = 9'd319; by[1] = 8'd239; bc[1] = 24'h123456; req_valid = 2'b10;
    wait_rdy(r);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk); @(negedge clk);
    chk("oob_next_write", mem_write, 1);
    chk("oob_next_addr", mem_address, 17'd76799);
    chk("oob_err_sticky", err_oob, 1);
    repeat (2) @(posedge clk);
`endif

    // Randomized traffic checked by the model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i[0]] && r[i[0]]) begin
          req_valid[i[0]] = 1'b0;
        end else if (req_valid[i[0]] && $urandom_range(0, 15) == 0) begin
          req_valid[i[0]] = 1'b0;
        end
        if (!req_valid[i[0]] && $urandom_range(0, 2) == 0) begin
          bx[i[0]] = 9'($urandom_range(0, 511));
          by[i[0]] = 8'($urandom_range(0, 255));
          bc[i[0]] = 24'($urandom);
          req_valid[i[0]] = 1'b1;
        end
      end
      mem_waitrequest = ($urandom_range(0, 3) == 0);
    end
    req_valid = 2'b00;
    mem_waitrequest = 1'b0;
    repeat (6) @(posedge clk);

    // NUM_REQ=4: move pointer to 2, then req3 beats req1.
    do_reset();
    v4 = 4'b0010;
    wait_rdy4(rr4); chk("q4_first", rr4, 4'b0010);
    @(posedge clk); #1 v4 = 4'b1010;
    wait_rdy4(rr4); chk("q4_req3", rr4, 4'b1000);
    chk("q4_gid3", gid4, 3);
    @(posedge clk); #1 v4[3] = 1'b0;
    wait_rdy4(rr4); chk("q4_req1", rr4, 4'b0010);
    @(posedge clk); #1 v4 = 4'b0000;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
